// File: rtl/demux64_wr.sv
// Purpose: 64-entry x W register bank with auto-pointer/explicit writes, distinct-write count and a 64-cycle clear sweep.
// Latency: accepted write visible on q the following cycle; clear completes 64 cycles after it is taken.
// Backpressure: wr_ready drops during the sweep and in the cycle clr is raised; writes seen while not ready are dropped.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   clr                 start a clear sweep (ignored while one is running)
//   wr_valid/wr_ready   write handshake; wr_auto selects ptr (1) or wr_addr (0) as target
//   wr_addr, wr_data    explicit write index and write data
//   q                   all entries, entry i at q[W*i +: W]
//   ptr, cnt            auto-increment pointer, distinct entries written since last clear (0..64)
//   full, busy          cnt == 64, sweep in progress

module demux64_wr #(
   parameter int W = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clr,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic            wr_auto,
   input  logic [5:0]      wr_addr,
   input  logic [W-1:0]    wr_data,
   output logic [64*W-1:0] q,
   output logic [5:0]      ptr,
   output logic [6:0]      cnt,
   output logic            full,
   output logic            busy
);

   typedef enum logic {
      READY = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   entry [64];
   logic [63:0]    written;
   logic [5:0]     target;
   logic           accept;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= READY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      busy      = 1'b0;
      case (state)
         READY: begin
            // clr takes priority over a same-cycle write, so refuse it here
            wr_ready = !clr;
            if (clr) begin
               state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            busy = 1'b1;
            if (ptr == 6'd63) begin
               state_nxt = READY;
            end
         end
         default: begin
            state_nxt = READY;
         end
      endcase
   end

   assign accept = wr_valid && wr_ready;
   assign target = wr_auto ? ptr : wr_addr;
   assign full   = (cnt == 7'd64);

   // Entry storage, written flags, pointer and count
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) begin
            entry[i] <= '0;
         end
         written <= '0;
         ptr     <= '0;
         cnt     <= '0;
      end else if (state == SWEEP) begin
         // ptr walks 0..63 and wraps back to 0 on the final clear
         entry[ptr]   <= '0;
         written[ptr] <= 1'b0;
         ptr          <= ptr + 6'd1;
         if (ptr == 6'd63) begin
            cnt <= '0;
         end
      end else if (clr) begin
         ptr <= '0;
      end else if (accept) begin
         entry[target]   <= wr_data;
         written[target] <= 1'b1;
         if (wr_auto) begin
            ptr <= ptr + 6'd1;
         end
         // only first writes since the last clear add to the count
         if (!written[target]) begin
            cnt <= cnt + 7'd1;
         end
      end
   end

   // Flatten entries onto the selector bus
   for (genvar g = 0; g < 64; g++) begin : g_q
      assign q[W*g +: W] = entry[g];
   end

endmodule

// File: tb/tb_demux64_wr.sv
module tb_demux64_wr;

   localparam int W = 4;

   logic            clk;
   logic            reset_n;
   logic            clr;
   logic            wr_valid;
   logic            wr_ready;
   logic            wr_auto;
   logic [5:0]      wr_addr;
   logic [W-1:0]    wr_data;
   logic [64*W-1:0] q;
   logic [5:0]      ptr;
   logic [6:0]      cnt;
   logic            full;
   logic            busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int           idx;
      logic [W-1:0] data;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] mdl [64];
   bit           mwr [64];
   int           mcnt;
   int           mptr;

   demux64_wr #(.W(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_auto  (wr_auto),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .q        (q),
      .ptr      (ptr),
      .cnt      (cnt),
      .full     (full),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         mdl[i] = '0;
         mwr[i] = 1'b0;
      end
      mcnt = 0;
      mptr = 0;
   endtask

   task automatic reset_dut();
      reset_n  = 1'b0;
      clr      = 1'b0;
      wr_valid = 1'b0;
      tick();
      reset_n  = 1'b1;
      model_clear();
      sb.delete();
   endtask

   // Drive one write through an edge; expected entry value goes to the scoreboard
   task automatic drive_write(input bit auto_w, input int addr, input logic [W-1:0] data);
      int   tgt;
      exp_t e;
      wr_valid = 1'b1;
      wr_auto  = auto_w;
      wr_addr  = 6'(addr);
      wr_data  = data;
      tgt      = auto_w ? mptr : addr;
      e.idx    = tgt;
      e.data   = data;
      sb.push_back(e);
      if (!mwr[tgt]) mcnt++;
      mwr[tgt] = 1'b1;
      mdl[tgt] = data;
      if (auto_w) mptr = (mptr + 1) % 64;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      clr      = 1'b1;
      wr_valid = 1'b1;
      wr_auto  = 1'b1;
      wr_data  = 4'hF;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (q !== '0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
      checks++; if (ptr !== 6'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", ptr); end
      checks++; if (cnt !== 7'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      clr      = 1'b0;
      wr_valid = 1'b0;
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      reset_n = 1'b1;
      model_clear();
      sb.delete();
   endtask

   task automatic test_auto_writes();
      exp_t e;
      reset_dut();
      for (int v = 1; v <= 3; v++) begin
         drive_write(1'b1, 0, 4'(v));
         e = sb.pop_front();
         checks++;
         if (q[e.idx*W +: W] !== e.data) begin
            errors++; $display("FAIL auto_q[%0d]: got %h want %h", e.idx, q[e.idx*W +: W], e.data);
         end
      end
      checks++; if (ptr !== 6'(mptr)) begin errors++; $display("FAIL auto_ptr: got %0d want %0d", ptr, mptr); end
      checks++; if (cnt !== 7'(mcnt)) begin errors++; $display("FAIL auto_cnt: got %0d want %0d", cnt, mcnt); end
   endtask

   task automatic test_full_wrap();
      exp_t e;
      reset_dut();
      for (int n = 1; n <= 65; n++) begin
         drive_write(1'b1, 0, (n == 65) ? 4'h5 : 4'hA);
         e = sb.pop_front();
         checks++;
         if (q[e.idx*W +: W] !== e.data) begin
            errors++; $display("FAIL full_q[%0d]: got %h want %h", e.idx, q[e.idx*W +: W], e.data);
         end
         if (n == 63) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0", full); end
         end
         if (n == 64) begin
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_at64: got %b want 1", full); end
            checks++; if (ptr !== 6'd0) begin errors++; $display("FAIL full_ptr_wrap: got %0d want 0", ptr); end
         end
      end
      checks++; if (cnt !== 7'd64) begin errors++; $display("FAIL full_cnt_stays: got %0d want 64", cnt); end
      checks++; if (ptr !== 6'(mptr)) begin errors++; $display("FAIL full_ptr_after: got %0d want %0d", ptr, mptr); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after_rewrite: got %b want 1", full); end
   endtask

   task automatic test_explicit();
      exp_t e;
      reset_dut();
      drive_write(1'b0, 10, 4'h3);
      e = sb.pop_front();
      checks++; if (q[e.idx*W +: W] !== e.data) begin errors++; $display("FAIL expl_first: got %h want %h", q[e.idx*W +: W], e.data); end
      drive_write(1'b0, 10, 4'hC);
      e = sb.pop_front();
      checks++; if (q[e.idx*W +: W] !== e.data) begin errors++; $display("FAIL expl_second: got %h want %h", q[e.idx*W +: W], e.data); end
      checks++; if (cnt !== 7'd1) begin errors++; $display("FAIL expl_cnt: got %0d want 1", cnt); end
      checks++; if (ptr !== 6'(mptr)) begin errors++; $display("FAIL expl_ptr: got %0d want %0d", ptr, mptr); end
   endtask

   // Runs a sweep, counting busy cycles; optionally pulses clr at sample pulse_at
   task automatic run_sweep(input string tag, input int pulse_at);
      int n;
      int cnt_hold;
      cnt_hold = mcnt;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_in_sweep: got %b want 0 at %0d", tag, wr_ready, n); end
         checks++; if (ptr !== 6'(n-1)) begin errors++; $display("FAIL %s_sweep_ptr: got %0d want %0d", tag, ptr, n-1); end
         checks++; if (cnt !== 7'(cnt_hold)) begin errors++; $display("FAIL %s_sweep_cnt: got %0d want %0d", tag, cnt, cnt_hold); end
         // a write attempt during the sweep must be dropped
         wr_valid = 1'b1;
         wr_auto  = 1'b0;
         wr_addr  = 6'd5;
         wr_data  = 4'hF;
         clr      = (n == pulse_at);
         tick();
         clr      = 1'b0;
         wr_valid = 1'b0;
      end
      model_clear();
      #1;
      checks++; if (n !== 64) begin errors++; $display("FAIL %s_busy_len: got %0d want 64", tag, n); end
      checks++; if (q !== '0) begin errors++; $display("FAIL %s_q_cleared: got %h want 0", tag, q); end
      checks++; if (cnt !== 7'd0) begin errors++; $display("FAIL %s_cnt_cleared: got %0d want 0", tag, cnt); end
      checks++; if (ptr !== 6'd0) begin errors++; $display("FAIL %s_ptr_cleared: got %0d want 0", tag, ptr); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after: got %b want 1", tag, wr_ready); end
   endtask

   task automatic test_clr_sweep();
      exp_t e;
      reset_dut();
      for (int v = 1; v <= 3; v++) begin
         drive_write(1'b1, 0, 4'(v + 6));
         e = sb.pop_front();
         checks++; if (q[e.idx*W +: W] !== e.data) begin errors++; $display("FAIL pre_sweep_q: got %h want %h", q[e.idx*W +: W], e.data); end
      end
      drive_write(1'b0, 40, 4'h9);
      e = sb.pop_front();
      checks++; if (q[e.idx*W +: W] !== e.data) begin errors++; $display("FAIL pre_sweep_q40: got %h want %h", q[e.idx*W +: W], e.data); end
      // clr and a write to a fresh address in the same cycle
      clr      = 1'b1;
      wr_valid = 1'b1;
      wr_auto  = 1'b0;
      wr_addr  = 6'd5;
      wr_data  = 4'h7;
      #1;
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b want 0", wr_ready); end
      tick();
      clr      = 1'b0;
      wr_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start: got %b want 1", busy); end
      run_sweep("clr", -1);
      // written flags must be cleared: a fresh write counts again
      drive_write(1'b0, 0, 4'h2);
      e = sb.pop_front();
      checks++; if (q[e.idx*W +: W] !== e.data) begin errors++; $display("FAIL post_sweep_q: got %h want %h", q[e.idx*W +: W], e.data); end
      checks++; if (cnt !== 7'd1) begin errors++; $display("FAIL post_sweep_cnt: got %0d want 1", cnt); end
   endtask

   task automatic test_clr_during_sweep();
      exp_t e;
      reset_dut();
      drive_write(1'b1, 0, 4'h4);
      e = sb.pop_front();
      checks++; if (q[e.idx*W +: W] !== e.data) begin errors++; $display("FAIL reclr_pre_q: got %h want %h", q[e.idx*W +: W], e.data); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      run_sweep("reclr", 10);
   endtask

   task automatic test_reset_mid_sweep();
      exp_t e;
      reset_dut();
      for (int n = 0; n < 40; n++) begin
         drive_write(1'b1, 0, 4'(n % 15 + 1));
         e = sb.pop_front();
         if (n == 39) begin
            checks++; if (q[e.idx*W +: W] !== e.data) begin errors++; $display("FAIL rst_sweep_pre_q: got %h want %h", q[e.idx*W +: W], e.data); end
         end
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int n = 1; n < 20; n++) tick();
      checks++; if (ptr !== 6'd19) begin errors++; $display("FAIL rst_sweep_ptr_mid: got %0d want 19", ptr); end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      model_clear();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_sweep_busy: got %b want 0", busy); end
      checks++; if (q !== '0) begin errors++; $display("FAIL rst_sweep_q: got %h want 0", q); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_sweep_ready: got %b want 1", wr_ready); end
      checks++; if (cnt !== 7'd0) begin errors++; $display("FAIL rst_sweep_cnt: got %0d want 0", cnt); end
      checks++; if (ptr !== 6'd0) begin errors++; $display("FAIL rst_sweep_ptr: got %0d want 0", ptr); end
   endtask

   initial begin
      reset_n  = 1'b0;
      clr      = 1'b0;
      wr_valid = 1'b0;
      wr_auto  = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      model_clear();
      test_reset();
      test_auto_writes();
      test_full_wrap();
      test_explicit();
      test_clr_sweep();
      test_clr_during_sweep();
      test_reset_mid_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
